cp_tx_sequencer: RTL and testbench

//  Sequences the transmit side of a node's comms processor on the photonic interconnect.
//  - Buffers GPP words.
//  - Issues a control request {node_id, word count} to the destination node.
//  - Waits for the destination's ready-ack on the control channel.
//  - Streams the buffered words as data packets {node_id, word}.
//  - Handles ack timeout with bounded retry.

---
 rtl/cp_tx_sequencer_if.sv | 33 +++
 rtl/cp_tx_sequencer.sv | 148 ++++++++++++++
 tb/tb_cp_tx_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp_tx_sequencer_if.sv
// Signal bundle between a comms-processor TX sequencer and its GPP/interconnect peers.
// master = the sequencer, slave = the environment that feeds it words and acks.
interface cp_tx_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   node_id;
    logic [15:0]   max_node;
    logic [15:0]   dest_id;
    logic          gpp_trf_dp;
    logic [15:0]   gpp_tx_data;
    logic [31:0]   control_rx_packet;
    logic [31:0]   control_tx_packet;
    logic [31:0]   data_tx_packet;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_fail;
    logic          tx_overflow;
    logic [CW-1:0] word_count;

    modport master (
        input  node_id, max_node, dest_id, gpp_trf_dp, gpp_tx_data, control_rx_packet,
        output control_tx_packet, data_tx_packet, tx_busy, tx_done, tx_fail,
               tx_overflow, word_count
    );

    modport slave (
        output node_id, max_node, dest_id, gpp_trf_dp, gpp_tx_data, control_rx_packet,
        input  control_tx_packet, data_tx_packet, tx_busy, tx_done, tx_fail,
               tx_overflow, word_count
    );
endinterface

// File: rtl/cp_tx_sequencer.sv
// Transmit sequencer: buffers GPP words, requests a destination, waits for its ack
// (with bounded retry), then streams the buffered words as data packets.
module cp_tx_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic      clk,
    input  logic      rst,
    cp_tx_if.master   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    // Timer reaching TIMEOUT-1 on this step means the request slot (incl. REQ) is used up.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACK, S_SEND, S_DONE, S_FAIL
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_dest;
    logic          r_prev_dp;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic [31:0]   r_ctrl_tx;
    logic [31:0]   r_data_tx;
    logic          r_busy;
    logic          r_done;
    logic          r_fail;
    logic          r_overflow;

    logic [15:0]   w_dest_sel;
    logic          w_dest_ok;
    logic          w_ack;
    logic          w_timeout;
    logic          w_write;
    logic          w_drop;
    logic          w_pop;
    logic          w_start;

    // The destination is checked on the cycle it is latched as well as on retries.
    assign w_dest_sel = (r_state == S_IDLE) ? bus.dest_id : r_dest;
    assign w_dest_ok  = (w_dest_sel != 16'h0) && (w_dest_sel != bus.node_id) &&
                        (w_dest_sel <= bus.max_node);
    assign w_ack      = (bus.control_rx_packet == {r_dest, 16'hFFFF});
    assign w_timeout  = (r_timer == TIMER_LAST);
    assign w_write    = (r_state == S_IDLE) && bus.gpp_trf_dp && (r_count != FULL);
    assign w_drop     = (r_state == S_IDLE) && bus.gpp_trf_dp && (r_count == FULL);
    assign w_start    = r_prev_dp && !bus.gpp_trf_dp && (r_count != '0);
    assign w_pop      = (w_state_next == S_SEND);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_next = S_REQ;
            S_REQ:      w_state_next = w_dest_ok ? S_WAIT_ACK : S_FAIL;
            S_WAIT_ACK: begin
                if (w_ack)
                    w_state_next = S_SEND;
                else if (w_timeout)
                    w_state_next = (r_retry < RETRY_MAX) ? S_REQ : S_FAIL;
            end
            S_SEND:     if (r_count == '0) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            S_FAIL:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= bus.gpp_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dest     <= '0;
            r_prev_dp  <= 1'b0;
            r_timer    <= '0;
            r_retry    <= '0;
            r_ctrl_tx  <= '0;
            r_data_tx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_prev_dp <= bus.gpp_trf_dp;
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= (w_state_next == S_DONE);
            r_fail    <= (w_state_next == S_FAIL);
            r_timer   <= (r_state == S_WAIT_ACK) ? r_timer + TW'(1) : '0;

            if (r_state == S_IDLE && w_state_next == S_REQ)
                r_dest <= bus.dest_id;

            if (r_state == S_WAIT_ACK && w_state_next == S_REQ)
                r_retry <= r_retry + RW'(1);
            else if (r_state == S_DONE || r_state == S_FAIL)
                r_retry <= '0;

            r_ctrl_tx <= (w_state_next == S_REQ && w_dest_ok) ?
                         {bus.node_id, 16'(r_count)} : '0;
            r_data_tx <= w_pop ? {bus.node_id, r_mem[r_rd_ptr]} : '0;

            if (r_state != S_IDLE && w_state_next == S_IDLE)
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;

            // Writes only happen in IDLE and pops only in SEND, so they never coincide.
            if (r_state == S_FAIL) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count  <= r_count + CW'(1);
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count  <= r_count - CW'(1);
            end
        end
    end

    assign bus.control_tx_packet = r_ctrl_tx;
    assign bus.data_tx_packet    = r_data_tx;
    assign bus.tx_busy           = r_busy;
    assign bus.tx_done           = r_done;
    assign bus.tx_fail           = r_fail;
    assign bus.tx_overflow       = r_overflow;
    assign bus.word_count        = r_count;
endmodule

// File: tb/tb_cp_tx_sequencer.sv
// Directed bench for cp_tx_sequencer: stimulus pushes expected packets/pulses into a
// scoreboard queue; a negedge monitor pops and compares every event the DUT presents.
module tb_cp_tx_sequencer;
    localparam int K_CTRL = 0;
    localparam int K_DATA = 1;
    localparam int K_DONE = 2;
    localparam int K_FAIL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp_tx_if #(.DEPTH(16)) bus ();

    cp_tx_sequencer #(.DEPTH(16), .TIMEOUT(64), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic observe(input int k, input logic [31:0] v);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event @%0d: got kind %0d value 0x%08h, expected none",
                     cyc, k, v);
        end else begin
            e = sb.pop_front();
            chk($sformatf("event_kind@%0d", cyc), k, e.kind);
            chk($sformatf("event_value@%0d", cyc), v, e.val);
            $display("cycle %0d: event kind %0d value 0x%08h", cyc, k, v);
        end
    endtask

    always @(negedge clk) begin
        if (bus.control_tx_packet !== 32'h0) observe(K_CTRL, bus.control_tx_packet);
        if (bus.data_tx_packet !== 32'h0)    observe(K_DATA, bus.data_tx_packet);
        if (bus.tx_done !== 1'b0)            observe(K_DONE, 32'h0);
        if (bus.tx_fail !== 1'b0)            observe(K_FAIL, 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        bus.gpp_trf_dp  = 1'b1;
        bus.gpp_tx_data = w;
        tick();
    endtask

    task automatic end_burst();
        bus.gpp_trf_dp  = 1'b0;
        bus.gpp_tx_data = 16'h0;
    endtask

    task automatic wait_ctrl(input string name, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.control_tx_packet !== 32'h0) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: no control request within 200 cycles, expected one", name);
        end
    endtask

    // which: 1 = tx_done seen, 2 = tx_fail seen, 0 = neither within the bound
    task automatic wait_end(output int which);
        which = 0;
        for (int i = 0; i < 400 && which == 0; i++) begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) which = 1;
            else if (bus.tx_fail === 1'b1) which = 2;
        end
    endtask

    task automatic send_ack(input logic [31:0] pkt);
        bus.control_rx_packet = pkt;
        tick();
        bus.control_rx_packet = 32'h0;
    endtask

    initial begin
        int t_prev;
        int t_now;
        int which;
        int n;
        logic [15:0] t1_words [5];

        t1_words[0] = 16'h000A;
        t1_words[1] = 16'h000B;
        t1_words[2] = 16'h000C;
        t1_words[3] = 16'h000D;
        t1_words[4] = 16'h0005;

        bus.node_id           = 16'd1;
        bus.max_node          = 16'd4;
        bus.dest_id           = 16'd2;
        bus.gpp_trf_dp        = 1'b0;
        bus.gpp_tx_data       = 16'h0;
        bus.control_rx_packet = 32'h0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl_tx", bus.control_tx_packet, 32'h0);
        chk("reset_data_tx", bus.data_tx_packet, 32'h0);
        chk("reset_busy", 32'(bus.tx_busy), 32'h0);
        chk("reset_done", 32'(bus.tx_done), 32'h0);
        chk("reset_fail", 32'(bus.tx_fail), 32'h0);
        chk("reset_overflow", 32'(bus.tx_overflow), 32'h0);
        chk("reset_word_count", 32'(bus.word_count), 32'h0);
        tick();

        // T1 basic transfer, ack two cycles after the request
        for (int i = 0; i < 5; i++) write_word(t1_words[i]);
        chk("t1_word_count", 32'(bus.word_count), 32'd5);
        push(K_CTRL, 32'h0001_0005);
        end_burst();
        wait_ctrl("t1_request", t_now);
        chk("t1_busy", 32'(bus.tx_busy), 32'h1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) push(K_DATA, {16'd1, t1_words[i]});
        push(K_DONE, 32'h0);
        send_ack(32'h0002_FFFF);
        @(negedge clk);
        chk("t1_first_data_latency", bus.data_tx_packet, 32'h0001_000A);
        wait_end(which);
        chk("t1_end_is_done", 32'(which), 32'd1);
        chk("t1_word_count_after", 32'(bus.word_count), 32'd0);
        tick();

        // T2 wrong source and wrong code are ignored
        write_word(16'h1111);
        write_word(16'h2222);
        push(K_CTRL, 32'h0001_0002);
        end_burst();
        wait_ctrl("t2_request", t_now);
        tick();
        send_ack(32'h0003_FFFF);
        send_ack(32'h0002_0000);
        @(negedge clk);
        chk("t2_no_data_after_bad_acks", bus.data_tx_packet, 32'h0);
        chk("t2_still_busy", 32'(bus.tx_busy), 32'h1);
        tick();
        push(K_DATA, 32'h0001_1111);
        push(K_DATA, 32'h0001_2222);
        push(K_DONE, 32'h0);
        send_ack(32'h0002_FFFF);
        wait_end(which);
        chk("t2_end_is_done", 32'(which), 32'd1);
        tick();

        // T3 no ack: four requests 64 cycles apart, then fail with buffer flushed
        for (int i = 1; i <= 5; i++) write_word(16'(32'h0100 + i));
        for (int i = 0; i < 4; i++) push(K_CTRL, 32'h0001_0005);
        push(K_FAIL, 32'h0);
        end_burst();
        wait_ctrl("t3_request_0", t_prev);
        for (int k = 1; k < 4; k++) begin
            wait_ctrl($sformatf("t3_request_%0d", k), t_now);
            chk($sformatf("t3_request_gap_%0d", k), 32'(t_now - t_prev), 32'd64);
            t_prev = t_now;
        end
        wait_end(which);
        chk("t3_end_is_fail", 32'(which), 32'd2);
        @(negedge clk);
        chk("t3_word_count_flushed", 32'(bus.word_count), 32'd0);
        chk("t3_idle_after_fail", 32'(bus.tx_busy), 32'h0);
        tick();

        // T4 overflow: 17 writes into a 16-deep buffer
        for (int i = 0; i < 17; i++) write_word(16'(32'h0200 + i));
        chk("t4_word_count_full", 32'(bus.word_count), 32'd16);
        chk("t4_overflow_set", 32'(bus.tx_overflow), 32'h1);
        push(K_CTRL, 32'h0001_0010);
        end_burst();
        wait_ctrl("t4_request", t_now);
        chk("t4_overflow_sticky", 32'(bus.tx_overflow), 32'h1);
        tick();
        for (int i = 0; i < 16; i++) push(K_DATA, 32'h0001_0200 + 32'(i));
        push(K_DONE, 32'h0);
        send_ack(32'h0002_FFFF);
        wait_end(which);
        chk("t4_end_is_done", 32'(which), 32'd1);
        @(negedge clk);
        chk("t4_overflow_cleared", 32'(bus.tx_overflow), 32'h0);
        tick();

        // T5 invalid destinations: own ID, then beyond max_node
        bus.dest_id = 16'd1;
        write_word(16'h0AAA);
        push(K_FAIL, 32'h0);
        end_burst();
        wait_end(which);
        chk("t5_own_id_fails", 32'(which), 32'd2);
        tick();
        bus.dest_id = 16'd5;
        write_word(16'h0BBB);
        push(K_FAIL, 32'h0);
        end_burst();
        wait_end(which);
        chk("t5_beyond_max_fails", 32'(which), 32'd2);
        @(negedge clk);
        chk("t5_word_count_flushed", 32'(bus.word_count), 32'd0);
        bus.dest_id = 16'd2;
        tick();

        // T6 reset after two data words, then a fresh transfer
        for (int i = 1; i <= 5; i++) write_word(16'(32'h0300 + i));
        push(K_CTRL, 32'h0001_0005);
        end_burst();
        wait_ctrl("t6_request", t_now);
        tick();
        for (int i = 1; i <= 5; i++) push(K_DATA, 32'h0001_0300 + 32'(i));
        push(K_DONE, 32'h0);
        send_ack(32'h0002_FFFF);
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (bus.data_tx_packet !== 32'h0) n++;
        end
        chk("t6_two_words_before_reset", 32'(n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_ctrl_tx_zero", bus.control_tx_packet, 32'h0);
        chk("t6_data_tx_zero", bus.data_tx_packet, 32'h0);
        chk("t6_idle", 32'(bus.tx_busy), 32'h0);
        chk("t6_word_count_zero", 32'(bus.word_count), 32'h0);
        repeat (5) @(negedge clk);
        tick();
        for (int i = 1; i <= 3; i++) write_word(16'(32'h0400 + i));
        push(K_CTRL, 32'h0001_0003);
        end_burst();
        wait_ctrl("t6_new_request", t_now);
        tick();
        for (int i = 1; i <= 3; i++) push(K_DATA, 32'h0001_0400 + 32'(i));
        push(K_DONE, 32'h0);
        send_ack(32'h0002_FFFF);
        wait_end(which);
        chk("t6_new_transfer_done", 32'(which), 32'd1);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
